// File: rtl/mul_div_sequencer_if.sv
// Purpose : handshake/operand/result bundle between a requester and mul_div_sequencer.
// Latency : pure wiring, no state.
// Backpressure: requester must hold off start while busy; a start seen while busy is dropped.
// Ports   : master drives start/op/operandA/operandB and reads busy/done/results;
//           slave (the sequencer) is the mirror image.
interface mul_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resultHi;
  logic [WIDTH-1:0] resultLo;
  logic             divByZero;

  modport master (
    output start, op, operandA, operandB,
    input  busy, done, resultHi, resultLo, divByZero
  );

  modport slave (
    input  start, op, operandA, operandB,
    output busy, done, resultHi, resultLo, divByZero
  );
endinterface

// File: rtl/mul_div_sequencer.sv
// Purpose : unsigned MULTU/DIVU by iterating one bit per cycle on a shared add/sub ALU.
// Latency : start accepted at edge 0 -> done in cycle WIDTH+1 (cycle 1 for divide-by-zero).
// Backpressure: busy from the cycle after accept through DONE; start is ignored (not queued) while busy.
// Ports   : clk, resetN (sync, active-low); bus (slave modport) carries start/op/operands in,
//           busy/done/resultHi/resultLo/divByZero out. All outputs are registered.

// Small MIPS-style ALU: ctl[2] inverts B and injects the carry (subtract),
// ctl[1:0] selects and / or / sum. The single adder here is the only one in the block.
module mul_div_alu #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctl,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;

  always_comb begin
    bx  = ctl[2] ? ~b : b;
    sum = a + bx + {{(WIDTH-1){1'b0}}, ctl[2]};
    case (ctl[1:0])
      2'b00:   y = a & bx;
      2'b01:   y = a | bx;
      default: y = sum;
    endcase
  end
endmodule

module mul_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                resetN,
  mul_div_sequencer_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             op_q;
  logic [WIDTH-1:0] b_q;
  // acc is the partial-product high half (multiply) or partial remainder (divide);
  // lo is the multiplier being shifted out (multiply) or the quotient being shifted in (divide).
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] lo;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             dbz_q;

  logic [WIDTH:0]   r_shl;
  logic [WIDTH:0]   alu_a;
  logic [WIDTH:0]   alu_y;
  logic [2:0]       alu_ctl;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic             last;

  // Divide shifts {R,Q} left before the trial subtract; multiply adds into acc as-is.
  assign r_shl   = {acc[WIDTH-1:0], lo[WIDTH-1]};
  assign alu_a   = op_q ? r_shl : acc;
  assign alu_ctl = op_q ? ALU_SUB : ALU_ADD;

  mul_div_alu #(.WIDTH(WIDTH+1)) u_alu (
    .a   (alu_a),
    .b   ({1'b0, b_q}),
    .ctl (alu_ctl),
    .y   (alu_y)
  );

  always_comb begin
    sum     = lo[0] ? alu_y : acc;
    acc_nxt = {1'b0, sum[WIDTH:1]};
    lo_nxt  = {sum[0], lo[WIDTH-1:1]};
    if (op_q) begin
      // Trial result negative (top bit set) means the divisor did not fit: restore.
      acc_nxt = alu_y[WIDTH] ? r_shl : alu_y;
      lo_nxt  = {lo[WIDTH-2:0], ~alu_y[WIDTH]};
    end
  end

  assign last = (count == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state  <= IDLE;
      count  <= '0;
      op_q   <= 1'b0;
      b_q    <= '0;
      acc    <= '0;
      lo     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q   <= bus.op;
            b_q    <= bus.operandB;
            acc    <= '0;
            lo     <= bus.operandA;
            count  <= '0;
            busy_q <= 1'b1;
            dbz_q  <= 1'b0;
            if (bus.op && (bus.operandB == '0)) begin
              // Divide by zero bypasses RUN; results published straight away.
              state  <= DONE;
              done_q <= 1'b1;
              res_hi <= bus.operandA;
              res_lo <= '1;
              dbz_q  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          lo    <= lo_nxt;
          count <= count + 1'b1;
          if (last) begin
            state  <= DONE;
            count  <= '0;
            done_q <= 1'b1;
            res_hi <= acc_nxt[WIDTH-1:0];
            res_lo <= lo_nxt;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.resultHi  = res_hi;
  assign bus.resultLo  = res_lo;
  assign bus.divByZero = dbz_q;
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Purpose : self-checking bench for mul_div_sequencer (WIDTH = 32).
// Latency : checks done arrives in cycle 33 (cycle 1 for divide-by-zero) after the accepting edge.
// Backpressure: exercises start-while-busy being dropped and start held high back-to-back.
module tb_mul_div_sequencer;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } vec_t;

  logic clk;
  logic resetN;
  int   compared;
  int   mismatched;
  exp_t sb[$];

  mul_div_sequencer_if #(.WIDTH(W)) bus ();

  mul_div_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic done directly with 64-bit multiply and native / and %.
  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    if (!op) begin
      p     = {32'b0, a} * {32'b0, b};
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.dbz = 1'b0;
    end else if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else begin
      e.hi  = a % b;
      e.lo  = a / b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.operandA = a;
    bus.operandB = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts cycles from 'base' (cycle n is sampled at the negedge after edge n-1),
  // expects done first seen in exp_cyc, then checks results against the scoreboard head.
  task automatic wait_done(input int base, input int exp_cyc, input string name);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc  = base;
    seen = 1'b0;
    while (!seen && cyc < base + 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL %s timeout: no done by cycle %0d, required in cycle %0d", name, cyc, exp_cyc);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      chk({name, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
      chk({name, " busy_at_done"}, 64'(bus.busy), 64'd1);
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL %s scoreboard: done seen, expected no result pending", name);
      end else begin
        e = sb.pop_front();
        chk({name, " resultHi"}, 64'(bus.resultHi), 64'(e.hi));
        chk({name, " resultLo"}, 64'(bus.resultLo), 64'(e.lo));
        chk({name, " divByZero"}, 64'(bus.divByZero), 64'(e.dbz));
      end
    end
  endtask

  vec_t tbl[6];

  initial begin
    compared   = 0;
    mismatched = 0;
    resetN       = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 1'b0;
    bus.operandA = '0;
    bus.operandB = '0;

    tbl[0] = '{op: 1'b0, a: 32'd7,          b: 32'd6,          hi: 32'd0,          lo: 32'd42,         dbz: 1'b0, cyc: 33};
    tbl[1] = '{op: 1'b0, a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   hi: 32'hFFFFFFFE,   lo: 32'h00000001,   dbz: 1'b0, cyc: 33};
    tbl[2] = '{op: 1'b1, a: 32'd100,        b: 32'd7,          hi: 32'd2,          lo: 32'd14,         dbz: 1'b0, cyc: 33};
    tbl[3] = '{op: 1'b1, a: 32'h80000000,   b: 32'd1,          hi: 32'd0,          lo: 32'h80000000,   dbz: 1'b0, cyc: 33};
    tbl[4] = '{op: 1'b1, a: 32'd7,          b: 32'd100,        hi: 32'd7,          lo: 32'd0,          dbz: 1'b0, cyc: 33};
    tbl[5] = '{op: 1'b1, a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   hi: 32'd0,          lo: 32'd1,          dbz: 1'b0, cyc: 33};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy",      64'(bus.busy),      64'd0);
    chk("reset done",      64'(bus.done),      64'd0);
    chk("reset resultHi",  64'(bus.resultHi),  64'd0);
    chk("reset resultLo",  64'(bus.resultLo),  64'd0);
    chk("reset divByZero", 64'(bus.divByZero), 64'd0);
    resetN = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      sb.push_back('{hi: tbl[i].hi, lo: tbl[i].lo, dbz: tbl[i].dbz});
      wait_done(0, tbl[i].cyc, $sformatf("vec%0d", i));
    end

    // done is a single-cycle pulse and busy drops the cycle after it.
    @(negedge clk);
    chk("post_done done", 64'(bus.done), 64'd0);
    chk("post_done busy", 64'(bus.busy), 64'd0);
    chk("post_done hold_lo", 64'(bus.resultLo), 64'd1);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 6; i++) begin
      logic         rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = i[0];
      ra  = $urandom;
      rb  = (i == 5) ? 32'($urandom_range(1, 255)) : $urandom;
      if (rb == '0) rb = 32'd3;
      issue(rop, ra, rb);
      sb.push_back(model(rop, ra, rb));
      wait_done(0, 33, $sformatf("rnd%0d", i));
    end

    // Divide by zero, then the next start clears divByZero but results hold until done.
    issue(1'b1, 32'd5, 32'd0);
    sb.push_back(model(1'b1, 32'd5, 32'd0));
    wait_done(0, 1, "div0");
    issue(1'b0, 32'd3, 32'd3);
    sb.push_back(model(1'b0, 32'd3, 32'd3));
    @(negedge clk);
    chk("div0_next busy",      64'(bus.busy),      64'd1);
    chk("div0_next divByZero", 64'(bus.divByZero), 64'd0);
    chk("div0_next hold_lo",   64'(bus.resultLo),  64'hFFFFFFFF);
    chk("div0_next hold_hi",   64'(bus.resultHi),  64'd5);
    wait_done(1, 33, "mul3x3");

    // start pulsed mid-run with other operands is ignored.
    issue(1'b0, 32'd1234, 32'd5678);
    sb.push_back(model(1'b0, 32'd1234, 32'd5678));
    repeat (10) @(negedge clk);
    chk("ignored busy", 64'(bus.busy), 64'd1);
    bus.start    = 1'b1;
    bus.op       = 1'b1;
    bus.operandA = 32'd999;
    bus.operandB = 32'd10;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(10, 33, "ignored_start");
    @(negedge clk);
    chk("ignored no_second_op busy", 64'(bus.busy), 64'd0);

    // start held high: second operation accepted the cycle after done's cycle.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = 1'b0;
    bus.operandA = 32'd1000;
    bus.operandB = 32'd1000;
    sb.push_back(model(1'b0, 32'd1000, 32'd1000));
    @(posedge clk);
    #1;
    bus.op       = 1'b1;
    bus.operandA = 32'd1000;
    bus.operandB = 32'd33;
    sb.push_back(model(1'b1, 32'd1000, 32'd33));
    wait_done(0, 33, "b2b_first");
    wait_done(33, 67, "b2b_second");
    bus.start = 1'b0;

    // Reset in the middle of a divide discards it.
    issue(1'b1, 32'd1000, 32'd7);
    repeat (12) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    chk("midreset busy",      64'(bus.busy),      64'd0);
    chk("midreset done",      64'(bus.done),      64'd0);
    chk("midreset resultHi",  64'(bus.resultHi),  64'd0);
    chk("midreset resultLo",  64'(bus.resultLo),  64'd0);
    chk("midreset divByZero", 64'(bus.divByZero), 64'd0);
    resetN = 1'b1;
    issue(1'b1, 32'd9, 32'd3);
    sb.push_back('{hi: 32'd0, lo: 32'd3, dbz: 1'b0});
    wait_done(0, 33, "after_reset_div");

    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mul_div_sequencer.md
# mul_div_sequencer

Multi-cycle controller that runs unsigned multiply and divide as a sequence of single-cycle add/subtract steps on an internal ALU instance. It gives the MIPS core MULTU/DIVU support without a dedicated array multiplier or divider. The block accepts one operation through a start/busy/done handshake and iterates one bit per cycle. It returns a double-width result (hi/lo) that stays stable until the next accepted start.

## Interface
- WIDTH, 32, operand width; results are 2×WIDTH split into hi/lo.
- clk  input  1  single clock; all state updates on its rising edge.
- resetN  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  1  0 = multiply (MULTU), 1 = divide (DIVU); sampled with start.
- operandA  input  WIDTH  multiplicand / dividend; sampled with start.
- operandB  input  WIDTH  multiplier / divisor; sampled with start.
- busy  output  1  high while an operation is in RUN or DONE.
- done  output  1  one-cycle pulse; results valid in that cycle and after.
- resultHi  output  WIDTH  multiply: upper product bits; divide: remainder.
- resultLo  output  WIDTH  multiply: lower product bits; divide: quotient.
- divByZero  output  1  set with done when a divide had operandB == 0; cleared on next accepted start.

## Operation
- States: IDLE, RUN, DONE. An iteration counter runs 0..WIDTH-1.
- IDLE: if start = 1, latch op, operandA and operandB, clear divByZero, then:
  - divide with operandB == 0 → DONE.
  - otherwise → RUN, count = 0.
- Shared datapath: one ALU instance of width WIDTH+1. Control is 3'b010 (add) for multiply steps and 3'b110 (subtract) for divide steps. No other adder exists in the block.
- Multiply (shift-add), registers {hi(WIDTH+1), lo(WIDTH)}, hi initialised to 0 and lo to operandA. Each RUN cycle:
  - sum = lo[0] ? hi + B : hi, where the ALU add is zero-extended to WIDTH+1.
  - {hi, lo} ← {sum, lo} >> 1.
  - After WIDTH steps, resultHi = hi[WIDTH-1:0] and resultLo = lo.
- Divide (restoring), R(WIDTH+1) = 0, Q = operandA. Each RUN cycle:
  - {R, Q} ← {R, Q} << 1.
  - trial = R − {0, B} via the ALU subtract.
  - If trial[WIDTH] == 0: R ← trial, Q[0] ← 1. Otherwise: R is kept, Q[0] ← 0.
  - After WIDTH steps, resultHi = R[WIDTH-1:0] and resultLo = Q.
- Divide by zero: resultLo = all ones, resultHi = operandA, divByZero = 1. RUN is skipped.
- RUN: count increments each cycle. When count == WIDTH-1 the step completes and the state moves to DONE.
- DONE: done = 1 for exactly one cycle, then → IDLE.
- resultHi, resultLo and divByZero hold their values from DONE until the next accepted start. They then hold the previous values until the new DONE; they are not exposed mid-operation.
- start while busy = 1 is ignored (not queued). start held high in IDLE after DONE begins a new operation.
- All arithmetic is unsigned modulo 2^WIDTH per half. There are no exceptions other than divByZero.

## Timing
- Reset (resetN = 0 at a clk edge, in any state, including mid-RUN): state → IDLE, count = 0. busy, done, divByZero, resultHi and resultLo all → 0. An in-flight operation is discarded.
- Latency: start accepted at edge 0, RUN during cycles 1..WIDTH, done high in cycle WIDTH+1. For WIDTH = 32, done is at cycle 33.
- Divide by zero: done high in cycle 1 after the accepting edge.
- busy rises in the cycle after acceptance and falls in the cycle after done. A new start is accepted no earlier than one cycle after done.
- Throughput: one operation per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Multiply 7 × 6 (WIDTH = 32, start at edge 0) → done in cycle 33 only, resultHi = 0, resultLo = 42, divByZero = 0.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF → resultHi = 0xFFFFFFFE, resultLo = 0x00000001.
- Divide 100 / 7 → resultLo = 14, resultHi = 2. Divide 0x80000000 / 1 → resultLo = 0x80000000, resultHi = 0.
- Divide 5 / 0 → done in cycle 1, divByZero = 1, resultLo = 0xFFFFFFFF, resultHi = 5. Next accepted start (3 × 3) clears divByZero and returns resultLo = 9.
- start pulsed with different operands at cycle 10 of a multiply → ignored; the original result is returned at cycle 33. Back-to-back: start held high → second operation completes in cycle 67.
- resetN low at cycle 12 of a divide → cycle 13: busy = 0, done = 0, results 0. A fresh 9 / 3 then yields quotient 3, remainder 0.
